// File: rtl/sensor_sample_pio.sv
// Multi-channel sample capture peripheral on an Avalon-MM slave port.
// Latches per-channel samples on strobes and tracks new/overrun flags.
module sensor_sample_pio #(
    parameter int DATA_W = 24,
    parameter int N_CH   = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [3:0]               address,
    input  logic                     read,
    input  logic                     write,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    input  logic [N_CH*DATA_W-1:0]   in_port,
    input  logic [N_CH-1:0]          in_valid,
    output logic                     irq
);

    logic              r_freeze;
    logic              r_irq_en;
    logic [N_CH-1:0]   r_new;
    logic [N_CH-1:0]   r_ovr;
    logic [N_CH-1:0]   r_mask;
    logic [15:0]       r_cnt;
    logic [DATA_W-1:0] r_hold [N_CH];
    logic [31:0]       r_readdata;
    logic              r_irq;

    logic [N_CH-1:0]   w_cap;
    logic [N_CH-1:0]   w_rd_clr;
    logic [N_CH-1:0]   w_new_w1c;
    logic [N_CH-1:0]   w_ovr_w1c;
    logic [N_CH-1:0]   w_new_nxt;
    logic [N_CH-1:0]   w_ovr_nxt;
    logic [4:0]        w_ncap;
    logic [31:0]       w_rdata;
    logic              w_sts_wr;
    logic              w_unused;

    assign w_unused = ^writedata;

    assign w_cap     = r_freeze ? '0 : in_valid;
    assign w_sts_wr  = write && (address == 4'd1);
    assign w_new_w1c = w_sts_wr ? writedata[N_CH-1:0] : '0;
    assign w_ovr_w1c = w_sts_wr ? writedata[8 +: N_CH] : '0;

    // A capture always wins over any same-edge clear of its flag.
    assign w_new_nxt = w_cap | (r_new & ~w_rd_clr & ~w_new_w1c);
    assign w_ovr_nxt = (w_cap & r_new) | (r_ovr & ~w_ovr_w1c);

    always_comb begin
        w_rd_clr = '0;
        w_ncap   = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_rd_clr[i] = read && (address == 4'(i + 4));
            w_ncap      = w_ncap + 5'(w_cap[i]);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            4'd0: w_rdata[1:0] = {r_irq_en, r_freeze};
            4'd1: begin
                w_rdata[N_CH-1:0]   = r_new;
                w_rdata[8 +: N_CH]  = r_ovr;
            end
            4'd2: w_rdata[N_CH-1:0] = r_mask;
            4'd3: w_rdata[15:0]     = r_cnt;
            default: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (address == 4'(i + 4))
                        w_rdata = 32'(r_hold[i]);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_freeze <= 1'b0;
            r_irq_en <= 1'b0;
            r_mask   <= '0;
        end else if (write) begin
            if (address == 4'd0) begin
                r_freeze <= writedata[0];
                r_irq_en <= writedata[1];
            end
            if (address == 4'd2)
                r_mask <= writedata[N_CH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_new <= '0;
            r_ovr <= '0;
            r_cnt <= '0;
        end else begin
            r_new <= w_new_nxt;
            r_ovr <= w_ovr_nxt;
            if (write && address == 4'd3)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 16'(w_ncap);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++)
                r_hold[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_cap[i])
                    r_hold[i] <= in_port[i*DATA_W +: DATA_W];
            end
        end
    end

    // Read data reflects pre-edge state, so a same-cycle capture is not seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (read)
                r_readdata <= w_rdata;
            r_irq <= r_irq_en & (|(r_new & r_mask));
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: doc/sensor_sample_pio.md
SENSOR_SAMPLE_PIO -- requirements
Module: sensor_sample_pio

Interface
REQ-001 SHALL have parameter DATA_W, default 24, channel sample width (1..32).
REQ-002 SHALL have parameter N_CH, default 4, number of input channels (1..8).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port address  input  4  Avalon-MM word address.
REQ-006 SHALL have port read  input  1  Avalon read strobe.
REQ-007 SHALL have port write  input  1  Avalon write strobe.
REQ-008 SHALL have port writedata  input  32  Avalon write data.
REQ-009 SHALL have port readdata  output  32  registered read data.
REQ-010 SHALL have port in_port  input  N_CH*DATA_W  channel samples; channel i at bits [i*DATA_W +: DATA_W], clk-synchronous.
REQ-011 SHALL have port in_valid  input  N_CH  per-channel one-cycle capture strobe, clk-synchronous.
REQ-012 SHALL have port irq  output  1  level interrupt.

Function
REQ-013 Register map SHALL be: 0 CTRL (bit0 freeze, bit1 irq_en; RW); 1 STATUS (bits[N_CH-1:0] new, bits[8+N_CH-1:8] overrun; W1C); 2 IRQ_MASK (bits[N_CH-1:0]; RW); 3 CAPTURE_CNT (16-bit; write any value clears it); 4..4+N_CH-1 channel hold registers (RO).
REQ-014 readdata SHALL update on the clock edge after read=1, one-cycle latency, zero-extended to 32 bits; unmapped addresses and unused bits SHALL read 0.
REQ-015 readdata SHALL hold its last value while read=0.
REQ-016 When in_valid[i]=1 and freeze=0, hold register i SHALL load in_port slice i on that edge.
REQ-017 Each capture SHALL set new[i]; if new[i] was already 1, overrun[i] SHALL also be set.
REQ-018 CAPTURE_CNT SHALL increment by the number of channels captured that cycle (0..N_CH), modulo 2^16 (wraps 0xFFFF+1 -> 0x0000).
REQ-019 A read of channel address 4+i SHALL clear new[i] on the same edge that registers readdata; readdata SHALL be the hold value before any same-cycle capture.
REQ-020 Capture and clear of new[i] on the same edge (read-clear or W1C) SHALL leave new[i]=1 (set wins); overrun SHALL be evaluated on the pre-clear value.
REQ-021 STATUS write SHALL clear each new/overrun bit whose writedata bit is 1; bits written 0 unchanged.
REQ-022 freeze=1 SHALL block all captures, new/overrun setting and CAPTURE_CNT increments; hold registers keep value.
REQ-023 Write to CAPTURE_CNT coincident with captures SHALL result in 0 (clear wins).
REQ-024 irq SHALL be registered: irq = irq_en AND OR(new & IRQ_MASK), updating one cycle after its inputs change.
REQ-025 Writes to read-only or unmapped addresses SHALL have no effect; simultaneous read and write SHALL perform both.

Reset
REQ-026 On reset_n=0, asynchronously: readdata=0, irq=0, CTRL=0, IRQ_MASK=0, STATUS=0, CAPTURE_CNT=0, all hold registers=0.
REQ-027 Reset asserted mid-operation SHALL discard pending captures; first capture after release SHALL be honoured on the first rising edge with reset_n=1.

Verification
REQ-028 Reset then read addresses 0..15 -> every readdata = 0x00000000; irq=0.
REQ-029 in_valid=4'b0001, in_port ch0=0xABCDEF; read addr 4 -> readdata=0x00ABCDEF one cycle later; STATUS then reads 0x00000000 (new cleared).
REQ-030 Two ch2 captures without read -> STATUS=0x00000404; write 0x00000400 to STATUS -> STATUS=0x00000004.
REQ-031 IRQ_MASK=0x2, CTRL=0x2, capture ch1 -> irq=1 one cycle after new[1] sets; read addr 5 -> irq=0 one cycle after clear.
REQ-032 CAPTURE_CNT preset to 0xFFFE via captures, then in_valid=4'b1111 one cycle -> CAPTURE_CNT=0x0002; CTRL=0x1 then in_valid pulses -> hold, STATUS, count unchanged.
REQ-033 Read addr 6 coincident with ch2 capture of 0x000123 (prior 0x000055) -> readdata=0x00000055, new[2]=1 afterwards.
